// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, optional parity and 1-2 stop bits,
// delivering good words through a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int  WIDTH_WORD    = 8,
  parameter int  CANT_BIT_STOP = 2,
  parameter int  PARITY_MODE   = 0,
  parameter real FREC_CLK_MHZ  = 100.0,
  parameter int  BAUD_RATE     = 9600,
  parameter int  FIFO_DEPTH    = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx,
  output logic [WIDTH_WORD-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_frame_error,
  output logic                  o_parity_error,
  output logic                  o_overrun
);
  localparam int DIV   = $rtoi(FREC_CLK_MHZ * 1.0e6 / (16.0 * BAUD_RATE) + 0.5);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [3:0]       LAST_DATA  = 4'(WIDTH_WORD - 1);
  localparam logic [3:0]       LAST_STOP  = 4'(CANT_BIT_STOP - 1);
  localparam logic [AW:0]      FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                r_state, w_state_next;
  logic                  r_rx_meta, r_rx_sync;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [3:0]            r_bit_tick, r_bit_cnt;
  logic [WIDTH_WORD-1:0] r_shift;
  logic                  r_par_bit, r_stop_err;
  logic                  w_tick, w_mid, w_done;
  logic                  w_frame_bad, w_ones_odd, w_parity_bad;
  logic                  w_push, w_pop, w_wr, w_full;

  logic [WIDTH_WORD-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_div_cnt <= '0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

  assign w_tick = (r_div_cnt == DIV_LAST);
  // Bit centre: 16 ticks after the previous centre.
  assign w_mid  = w_tick && (r_bit_tick == 4'd15);

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: defaults assigned first so no path through the case infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE:   if (w_tick && !r_rx_sync) w_state_next = S_START;
      S_START:  if (w_tick && r_bit_tick == 4'd7)
                  w_state_next = r_rx_sync ? S_IDLE : S_DATA;
      S_DATA:   if (w_mid && r_bit_cnt == LAST_DATA)
                  w_state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_mid) w_state_next = S_STOP;
      S_STOP:   if (w_mid && r_bit_cnt == LAST_STOP) begin
                  w_state_next = S_IDLE;
                  w_done       = 1'b1;
                end
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_bit_tick <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_stop_err <= 1'b0;
    end else if (w_tick) begin
      if (r_state == S_IDLE || w_state_next != r_state) begin
        r_bit_tick <= '0;
        r_bit_cnt  <= '0;
      end else begin
        r_bit_tick <= r_bit_tick + 4'd1;
        if (w_mid) r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (r_state == S_DATA && w_mid)   r_shift   <= {r_rx_sync, r_shift[WIDTH_WORD-1:1]};
      if (r_state == S_PARITY && w_mid) r_par_bit <= r_rx_sync;
      if (r_state == S_START)                         r_stop_err <= 1'b0;
      else if (r_state == S_STOP && w_mid && !r_rx_sync) r_stop_err <= 1'b1;
    end
  end

  // The last stop sample is still combinational here, so fold it in directly.
  assign w_frame_bad  = r_stop_err | ~r_rx_sync;
  assign w_ones_odd   = ^{r_par_bit, r_shift};
  assign w_parity_bad = (PARITY_MODE == 1) ? ~w_ones_odd :
                        (PARITY_MODE == 2) ?  w_ones_odd : 1'b0;
  assign w_push       = w_done && !w_frame_bad && !w_parity_bad;

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign w_full  = (r_count == FULL_COUNT);
  assign w_pop   = o_valid && i_ready;
  assign w_wr    = w_push && (!w_full || w_pop);

  // NOTE: storage is not reset; o_valid gates every read so stale entries never escape.
  always_ff @(posedge i_clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      o_frame_error  <= 1'b0;
      o_parity_error <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      o_frame_error  <= w_done && w_frame_bad;
      o_parity_error <= w_done && !w_frame_bad && w_parity_bad;
      o_overrun      <= w_push && w_full && !w_pop;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo;
  localparam int  W     = 8;
  localparam int  NSTOP = 2;
  localparam int  PMODE = 2;
  localparam int  DEPTH = 4;
  localparam int  BAUD  = 1_000_000;
  localparam real FCLK  = 48.0;
  localparam int  DIV   = 3;               // 48e6 / (16 * 1e6)
  localparam int  BIT   = 16 * DIV;        // clocks per bit
  localparam int  PB    = (PMODE != 0) ? 1 : 0;
  localparam int  NSAMP = W + PB + NSTOP;

  logic         clk = 1'b0;
  logic         i_reset, i_rx, i_ready;
  logic [W-1:0] o_data;
  logic         o_valid, o_frame_error, o_parity_error, o_overrun;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .WIDTH_WORD(W), .CANT_BIT_STOP(NSTOP), .PARITY_MODE(PMODE),
    .FREC_CLK_MHZ(FCLK), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_rx(i_rx),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_frame_error(o_frame_error), .o_parity_error(o_parity_error),
    .o_overrun(o_overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: line sampled at tick offsets 8 + 16k from the start tick.
  logic         m_s1, m_s2;
  int           m_n, m_ts;
  bit           m_busy;
  bit           m_bits [NSAMP];
  logic [W-1:0] m_q [$];
  bit           e_fe, e_pe, e_ov;

  always @(posedge clk) begin : model
    bit tk, ln, done, stop_ok, par_x;
    int k;
    logic [W-1:0] d;
    if (i_reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_n = 0; m_busy = 0; m_ts = 0;
      m_q.delete();
      e_fe = 0; e_pe = 0; e_ov = 0;
    end else begin
      tk = (m_n % DIV == DIV - 1);
      ln = m_s2;
      m_s2 = m_s1; m_s1 = i_rx; m_n++;
      e_fe = 0; e_pe = 0; e_ov = 0; done = 0;
      if (tk) begin
        if (!m_busy) begin
          if (!ln) begin m_busy = 1; m_ts = 0; end
        end else begin
          m_ts++;
          if (m_ts == 8) begin
            if (ln) m_busy = 0;
          end else if (m_ts > 8 && (m_ts - 8) % 16 == 0) begin
            k = (m_ts - 8) / 16;
            m_bits[k-1] = ln;
            if (k == NSAMP) begin done = 1; m_busy = 0; end
          end
        end
      end
      if (m_q.size() > 0 && i_ready) void'(m_q.pop_front());
      if (done) begin
        d = '0;
        for (int i = 0; i < W; i++) d[i] = m_bits[i];
        stop_ok = 1;
        for (int i = W + PB; i < NSAMP; i++) if (!m_bits[i]) stop_ok = 0;
        par_x = ^d;
        if (PMODE != 0) par_x = par_x ^ m_bits[W];
        if (!stop_ok)                                e_fe = 1;
        else if (PMODE != 0 && par_x != (PMODE == 1)) e_pe = 1;
        else if (m_q.size() < DEPTH)                 m_q.push_back(d);
        else                                         e_ov = 1;
      end
    end
  end

  bit           chk_en = 0;
  int           fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  logic [W-1:0] pop_log [$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", o_valid, m_q.size() > 0);
      check("data", o_data, (m_q.size() > 0) ? m_q[0] : '0);
      check("frame_error", o_frame_error, e_fe);
      check("parity_error", o_parity_error, e_pe);
      check("overrun", o_overrun, e_ov);
      fe_cnt += int'(o_frame_error);
      pe_cnt += int'(o_parity_error);
      ov_cnt += int'(o_overrun);
      if (o_valid && i_ready) pop_log.push_back(o_data);
    end
  end

  bit rand_ready = 0;
  int fe0, pe0, ov0;

  task automatic step();
    @(posedge clk);
    #2;
    if (rand_ready) i_ready = ($urandom_range(0, 7) == 0);
  endtask

  task automatic snap();
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit bad_par,
                            input bit s0, input bit s1, input int gap);
    i_rx = 1'b0; repeat (BIT) step();
    for (int i = 0; i < W; i++) begin
      i_rx = d[i]; repeat (BIT) step();
    end
    i_rx = (^d) ^ bad_par; repeat (BIT) step();
    i_rx = s0; repeat (BIT) step();
    i_rx = s1; repeat (BIT) step();
    i_rx = 1'b1; repeat (gap) step();
  endtask

  task automatic pop_all();
    i_ready = 1'b1; repeat (8) step(); i_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d;
    i_reset = 1'b1; i_rx = 1'b1; i_ready = 1'b0;
    repeat (3) step();
    chk_en = 1;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_pulses", {o_frame_error, o_parity_error, o_overrun}, 0);
    i_reset = 1'b0;
    repeat (5) step();

    // Good frame held in the FIFO with the consumer stalled.
    snap();
    send_frame(8'h41, 0, 1, 1, 2 * BIT);
    check("f41_valid", o_valid, 1);
    check("f41_data", o_data, 8'h41);
    check("f41_no_err", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
    pop_all();

    // Wrong parity bit, then the correct one.
    snap();
    send_frame(8'h03, 1, 1, 1, 2 * BIT);
    check("par_pulse", pe_cnt - pe0, 1);
    check("par_no_push", o_valid, 0);
    send_frame(8'h03, 0, 1, 1, 2 * BIT);
    check("par_ok_data", o_data, 8'h03);
    check("par_ok_valid", o_valid, 1);
    pop_all();

    // First stop bit low.
    snap();
    send_frame(8'h55, 0, 0, 1, 2 * BIT);
    check("fe_pulse", fe_cnt - fe0, 1);
    check("fe_no_push", o_valid, 0);

    // Five words into a four-deep FIFO.
    snap();
    for (int v = 1; v <= 5; v++) send_frame(W'(v), 0, 1, 1, BIT);
    check("ovr_pulse", ov_cnt - ov0, 1);
    pop_log.delete();
    pop_all();
    check("ovr_pop_count", pop_log.size(), 4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++) check("ovr_pop_order", pop_log[i], i + 1);
    check("ovr_empty", o_valid, 0);

    // Three-tick glitch on an idle line.
    snap();
    i_rx = 1'b0; repeat (3 * DIV) step();
    i_rx = 1'b1; repeat (2 * BIT) step();
    check("glitch_no_push", o_valid, 0);
    check("glitch_no_err", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);

    // Reset in the data bits of 0xA5; the sender abandons the frame too.
    snap();
    d = 8'hA5;
    i_rx = 1'b0; repeat (BIT) step();
    for (int i = 0; i < 3; i++) begin i_rx = d[i]; repeat (BIT) step(); end
    i_reset = 1'b1; step(); i_reset = 1'b0;
    i_rx = 1'b1; repeat (14 * BIT) step();
    check("rst_mid_no_push", o_valid, 0);
    check("rst_mid_no_err", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
    send_frame(8'h3C, 0, 1, 1, 2 * BIT);
    check("rst_mid_next", o_data, 8'h3C);
    pop_all();

    // Random traffic against the model with a mostly stalled consumer.
    rand_ready = 1;
    for (int n = 0; n < 50; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        i_rx = 1'b0; repeat ($urandom_range(1, 5 * DIV)) step();
        i_rx = 1'b1; repeat (BIT) step();
      end
      send_frame(W'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3 * BIT));
    end
    rand_ready = 0;
    i_ready = 1'b1;
    repeat (14 * BIT) step();
    check("final_drained", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
